// File: rtl/fifo_uart_tx_if.sv
// Bundle between the byte FIFO read side / host control and the UART drain stage.
// The slave modport is the drain stage; the master side is the FIFO plus pin consumer.
interface fifo_uart_tx_if;
   logic       ena;
   logic       fifo_empty;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data;
   logic       tx;
   logic       busy;
   logic       frame_done;

   modport master (
      output ena, fifo_empty, fifo_rd_data,
      input  fifo_rd_en, tx, busy, frame_done
   );

   modport slave (
      input  ena, fifo_empty, fifo_rd_data,
      output fifo_rd_en, tx, busy, frame_done
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops bytes and sends them as 8N1 UART frames, LSB first.
// Optional even-parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic           clk,
   input  logic           rst,
   fifo_uart_tx_if.slave  io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRELAST = CNT_W'(CLKS_PER_BIT - 2);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shreg;
   logic             r_tx;
   logic             r_rd_en;
   logic             r_busy;
   logic             r_frame_done;

   logic             w_start;
   logic             w_bit_end;

   assign w_start   = io_bus.ena && !io_bus.fifo_empty;
   assign w_bit_end = (r_cnt == LAST);

`ifdef FIFO_UART_TX_PARITY_EN
   logic r_par;

   function automatic logic even_parity(input logic [7:0] b);
      return ^b;
   endfunction

   always_ff @(posedge clk) begin
      if (r_state == S_LOAD)
         r_par <= even_parity(io_bus.fifo_rd_data);
   end
`endif

   // Shift register is pure data: loaded in LOAD, shifted as each bit is launched.
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD)
         r_shreg <= io_bus.fifo_rd_data;
      else if (w_bit_end && (r_state == S_START || r_state == S_DATA))
         r_shreg <= {1'b0, r_shreg[7:1]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_tx         <= 1'b1;
         r_rd_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_rd_en      <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_FETCH;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_FETCH: r_state <= S_LOAD;
            S_LOAD: begin
               r_tx    <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_START;
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
                  r_tx      <= r_shreg[0];
                  r_state   <= S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shreg[0];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               // frame_done is registered one cycle early so it lands on the final stop cycle.
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (w_start) begin
                     r_state <= S_FETCH;
                     r_rd_en <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == PRELAST)
                     r_frame_done <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign io_bus.tx         = r_tx;
   assign io_bus.fifo_rd_en = r_rd_en;
   assign io_bus.busy       = r_busy;
   assign io_bus.frame_done = r_frame_done;

endmodule
